// File: rtl/tdc_mux_pkg.sv
// tdc_mux_pkg: shared FSM state and mode constants for the TDC channel multiplexer.
// Scan support in the multiplexer is selected with the TDC_MUX_SCAN_EN macro.
package tdc_mux_pkg;

    typedef logic [0:0] state_t;

    localparam state_t EMPTY = 1'b0;
    localparam state_t FULL  = 1'b1;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/tdc_rr_pick.sv
// tdc_rr_pick: combinational rotating first-one finder.
// Searches req starting at ptr, wrapping past NCH-1 back to 0.
// Used by tdc_chan_mux only when TDC_MUX_SCAN_EN is defined.
module tdc_rr_pick
    import tdc_mux_pkg::*;
#(
    parameter  int NCH   = 4,
    localparam int SEL_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_idx
);

    // Walk offsets from farthest to nearest so the request closest to ptr is the last one written.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] pos;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        pos         = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            pos = idx[SEL_W-1:0];
            if (req[pos]) begin
                grant_valid = 1'b1;
                grant_idx   = pos;
            end
        end
    end

endmodule

// File: rtl/tdc_chan_mux.sv
// tdc_chan_mux: registered NCH:1 channel multiplexer with a valid/ready output register.
// Define TDC_MUX_SCAN_EN to add round-robin scanning (mode=1) and its ptr register;
// without it the block is manual-select only and mode is ignored.
module tdc_chan_mux
    import tdc_mux_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int W     = 1,
    localparam int SEL_W = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH*W-1:0]   din,
    input  logic [NCH-1:0]     ch_valid,
    output logic [NCH-1:0]     ch_ack,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic               sel_err,
    output logic [W-1:0]       out_data,
    output logic [SEL_W-1:0]   out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [SEL_W:0] NCH_V = NCH[SEL_W:0];

    state_t           state_q, state_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic [NCH-1:0]   ch_ack_q, ch_ack_d;
    logic             sel_err_q, sel_err_d;

    logic             mode_eff;
    logic             scan_valid;
    logic [SEL_W-1:0] scan_idx;
    logic             sel_ok;
    logic             man_valid;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             load;
    logic             capture;

`ifdef TDC_MUX_SCAN_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;

    tdc_rr_pick #(
        .NCH (NCH)
    ) u_rr_pick (
        .req         (ch_valid),
        .ptr         (ptr_q),
        .grant_valid (scan_valid),
        .grant_idx   (scan_idx)
    );

    assign mode_eff = mode;

    // Advance the scan pointer past whichever channel was just captured; hold otherwise.
    always_comb begin
        ptr_d = ptr_q;
        if (capture) begin
            ptr_d = ({1'b0, grant_idx} == NCH_V - 1'b1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Scan pointer register, cleared only by reset so mode changes keep the rotation position.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign mode_eff    = MODE_MANUAL;
    assign scan_valid  = 1'b0;
    assign scan_idx    = '0;
`endif

    // Pick the granted channel for the active mode and decide whether the output register can load.
    always_comb begin
        sel_ok    = ({1'b0, sel} < NCH_V);
        man_valid = sel_ok && ch_valid[sel];
        if (mode_eff == MODE_SCAN) begin
            grant_valid = scan_valid;
            grant_idx   = scan_idx;
        end else begin
            grant_valid = man_valid;
            grant_idx   = sel;
        end
        load    = (state_q == EMPTY) || out_ready;
        capture = load && grant_valid;
    end

    // Next output register contents, acknowledge pulse and sticky select error.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        ch_ack_d   = '0;
        sel_err_d  = sel_err_q || ((mode_eff == MODE_MANUAL) && load && !sel_ok);
        if (load) begin
            state_d = capture ? FULL : EMPTY;
        end
        if (capture) begin
            out_data_d          = din[int'(grant_idx) * W +: W];
            out_ch_d            = grant_idx;
            ch_ack_d[grant_idx] = 1'b1;
        end
    end

    // Output register and FSM; reset discards any held word and suppresses the acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_ch_q   <= '0;
            ch_ack_q   <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            ch_ack_q   <= ch_ack_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign ch_ack    = ch_ack_q;
    assign sel_err   = sel_err_q;

endmodule
